// File: rtl/signed_seq_multiplier_if.sv
// Operand/result handshake bundle for signed_seq_multiplier.
// master: operand issuer and result consumer; slave: the multiplier.
interface signed_seq_multiplier_if #(
    parameter int WIDTH = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic signed [WIDTH-1:0]   a;
    logic signed [WIDTH-1:0]   b;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [2*WIDTH-1:0] product;
    logic                      busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/signed_seq_multiplier.sv
// Sequential signed 16x16 -> 32 shift-add multiplier.
// Operands are reduced to magnitudes, multiplied one partial-product bit per
// cycle, then the sign is reapplied and the product is offered on a
// valid/ready handshake. Only one operation is in flight at a time.
// Optional build macro EARLY_TERM_EN: once the remaining multiplier bits are
// all zero, the accumulator is aligned in a single step and the remaining
// iterations are skipped. The product value is identical in both builds.
module signed_seq_multiplier #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    signed_seq_multiplier_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic signed [WIDTH-1:0] a_q;
    logic signed [WIDTH-1:0] b_q;
    logic                    sign_q;
    logic [WIDTH-1:0]        mcand_q;
    logic [WIDTH-1:0]        mplier_q;
    logic [PW-1:0]           acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [PW-1:0]           product_q;
    logic                    out_valid_q;
    logic                    in_ready_q;
    logic                    busy_q;

    logic [WIDTH:0]          sum_d;

    // Two's-complement negation of an operand-width value (0x8000 maps to itself).
    function automatic logic [WIDTH-1:0] negate_op(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    // Magnitude of a signed operand; 0x8000 yields unsigned 32768.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? negate_op(x) : x;
    endfunction

    // Two's-complement negation of a product-width value (0 stays 0).
    function automatic logic [PW-1:0] negate_prod(input logic [PW-1:0] x);
        return ~x + PW'(1);
    endfunction

    // Upper accumulator half plus the multiplicand when the current multiplier bit is set; carry kept.
    always_comb begin
        sum_d = {1'b0, acc_q[PW-1:WIDTH]};
        if (mplier_q[0]) begin
            sum_d = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, mcand_q};
        end
    end

`ifdef EARLY_TERM_EN
    localparam logic [CNT_W:0] ITERS = (CNT_W + 1)'(WIDTH);
    logic [CNT_W:0] shamt_d;

    // Number of single-bit shifts still owed when the remaining multiplier is zero.
    always_comb begin
        shamt_d = ITERS - {1'b0, cnt_q};
    end
`endif

    // Control FSM with registered datapath and handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        sign_q     <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_CONV;
                    end
                end
                S_CONV: begin
                    mcand_q  <= magnitude(a_q);
                    mplier_q <= magnitude(b_q);
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    state_q  <= S_ITER;
                end
                S_ITER: begin
`ifdef EARLY_TERM_EN
                    if (mplier_q == '0) begin
                        acc_q   <= acc_q >> shamt_d;
                        state_q <= S_FIX;
                    end else begin
                        acc_q    <= {sum_d, acc_q[WIDTH-1:1]};
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_q <= S_FIX;
                        end
                    end
`else
                    acc_q    <= {sum_d, acc_q[WIDTH-1:1]};
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q <= S_FIX;
                    end
`endif
                end
                S_FIX: begin
                    product_q   <= sign_q ? negate_prod(acc_q) : acc_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_signed_seq_multiplier.sv
// Directed-vector bench for signed_seq_multiplier.
module tb_signed_seq_multiplier;
    localparam int LAT_MAX = 40;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    signed_seq_multiplier_if #(.WIDTH(16)) bus ();

    signed_seq_multiplier #(.WIDTH(16), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation, wait for the result, capture it, then complete the handshake.
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                         output logic [31:0] prod, output int lat,
                         output logic busy_seen, output logic rdy_seen,
                         output logic [31:0] prod_after);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 16'h5A5A;
        bus.b        = 16'hA5A5;
        busy_seen    = bus.busy;
        rdy_seen     = bus.in_ready;
        lat          = 0;
        while (!bus.out_valid && lat < LAT_MAX) begin
            @(posedge clk);
            #1;
            lat++;
        end
        prod = bus.product;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        prod_after    = bus.product;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.product !== 32'h0) begin
            errors++;
            $display("FAIL reset_product: got %h expected 00000000", bus.product);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", bus.busy);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] p, pa;
        int          lat;
        logic        bs, rs;
        do_op(16'd3, 16'd5, p, lat, bs, rs, pa);
        checks++;
        if (p !== 32'h0000_000F) begin
            errors++;
            $display("FAIL basic_3x5: got %h expected 0000000f", p);
        end
`ifndef EARLY_TERM_EN
        checks++;
        if (lat !== 18) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 18", lat);
        end
`endif
        checks++;
        if (bs !== 1'b1 || rs !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_after_accept: got busy=%b in_ready=%b expected busy=1 in_ready=0", bs, rs);
        end
        checks++;
        if (pa !== 32'h0000_000F || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_after_handshake: got product=%h out_valid=%b in_ready=%b expected 0000000f 0 1",
                     pa, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_signed();
        logic [31:0] p, pa;
        int          lat;
        logic        bs, rs;
        do_op(16'hFFF9, 16'd6, p, lat, bs, rs, pa);
        checks++;
        if (p !== 32'hFFFF_FFD6) begin
            errors++;
            $display("FAIL signed_m7x6: got %h expected ffffffd6", p);
        end
        do_op(16'h8000, 16'h8000, p, lat, bs, rs, pa);
        checks++;
        if (p !== 32'h4000_0000) begin
            errors++;
            $display("FAIL signed_min_x_min: got %h expected 40000000", p);
        end
        do_op(16'hFFFF, 16'hFFFF, p, lat, bs, rs, pa);
        checks++;
        if (p !== 32'h0000_0001) begin
            errors++;
            $display("FAIL signed_m1xm1: got %h expected 00000001", p);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] p, pa;
        int          lat;
        logic        bs, rs;
        do_op(16'h8000, 16'd1, p, lat, bs, rs, pa);
        checks++;
        if (p !== 32'hFFFF_8000) begin
            errors++;
            $display("FAIL bound_min_x1: got %h expected ffff8000", p);
        end
        do_op(16'd0, 16'hFFFF, p, lat, bs, rs, pa);
        checks++;
        if (p !== 32'h0000_0000) begin
            errors++;
            $display("FAIL bound_0xm1: got %h expected 00000000", p);
        end
        do_op(16'h7FFF, 16'h8000, p, lat, bs, rs, pa);
        checks++;
        if (p !== 32'hC000_8000) begin
            errors++;
            $display("FAIL bound_max_x_min: got %h expected c0008000", p);
        end
    endtask

    task automatic test_backpressure();
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        bus.a        = 16'd100;
        bus.b        = 16'hFFFD;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        // keep presenting a different pair while busy; it must not be taken
        bus.a = 16'd1;
        bus.b = 16'd1;
        w = 0;
        while (!bus.out_valid && w < LAT_MAX) begin
            @(posedge clk);
            #1;
            w++;
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.product !== 32'hFFFF_FED4 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got out_valid=%b product=%h in_ready=%b expected 1 fffffed4 0",
                         i, bus.out_valid, bus.product, bus.in_ready);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got out_valid=%b in_ready=%b expected 0 1", bus.out_valid, bus.in_ready);
        end
        // in_valid still high: the pending pair is accepted in this IDLE cycle
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reaccept_busy: got %b expected 1", bus.busy);
        end
        w = 0;
        while (!bus.out_valid && w < LAT_MAX) begin
            @(posedge clk);
            #1;
            w++;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.product !== 32'h0000_0001) begin
            errors++;
            $display("FAIL reaccept_product: got out_valid=%b product=%h expected 1 00000001", bus.out_valid, bus.product);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] p, pa;
        int          lat;
        logic        bs, rs;
        do_op(16'd7, 16'hFFF8, p, lat, bs, rs, pa);
        checks++;
        if (p !== 32'hFFFF_FFC8) begin
            errors++;
            $display("FAIL b2b_first: got %h expected ffffffc8", p);
        end
        do_op(16'd1234, 16'd10, p, lat, bs, rs, pa);
        checks++;
        if (p !== 32'h0000_3034) begin
            errors++;
            $display("FAIL b2b_second: got %h expected 00003034", p);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] p, pa;
        int          lat;
        logic        bs, rs;
        logic        seen_valid;
        @(negedge clk);
        bus.a        = 16'd300;
        bus.b        = 16'd300;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.product !== 32'h0) begin
            errors++;
            $display("FAIL midreset_state: got in_ready=%b busy=%b out_valid=%b product=%h expected 1 0 0 00000000",
                     bus.in_ready, bus.busy, bus.out_valid, bus.product);
        end
        @(negedge clk);
        reset = 1'b0;
        seen_valid = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_no_result: got out_valid seen=%b expected 0", seen_valid);
        end
        do_op(16'd2, 16'd3, p, lat, bs, rs, pa);
        checks++;
        if (p !== 32'h0000_0006) begin
            errors++;
            $display("FAIL midreset_recover: got %h expected 00000006", p);
        end
    endtask

    task automatic test_early_term();
        logic [31:0] p, pa;
        int          lat;
        logic        bs, rs;
        do_op(16'd123, 16'd0, p, lat, bs, rs, pa);
        checks++;
        if (p !== 32'h0) begin
            errors++;
            $display("FAIL et_b0_product: got %h expected 00000000", p);
        end
`ifdef EARLY_TERM_EN
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL et_b0_latency: got %0d expected 3", lat);
        end
`else
        checks++;
        if (lat !== 18) begin
            errors++;
            $display("FAIL et_b0_latency: got %0d expected 18", lat);
        end
`endif
        do_op(16'd9, 16'd1, p, lat, bs, rs, pa);
        checks++;
        if (p !== 32'h0000_0009) begin
            errors++;
            $display("FAIL et_b1_product: got %h expected 00000009", p);
        end
`ifdef EARLY_TERM_EN
        checks++;
        if (lat >= 18) begin
            errors++;
            $display("FAIL et_b1_latency: got %0d expected below 18", lat);
        end
`else
        checks++;
        if (lat !== 18) begin
            errors++;
            $display("FAIL et_b1_latency: got %0d expected 18", lat);
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_signed();
        test_boundary();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_early_term();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
